// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_if.sv
// Ratio configuration port: valid/ready handshake plus a reject pulse.
interface clk_div_cfg_if #(parameter int DIV_W = 16);

  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/clk_div_core.sv
// Period counter with registered clk_out/tick; run is the controller's next-cycle run decision.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             last
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] half;
  logic             active;

  assign half = div >> 1;
  assign last = active && (cnt == div - DIV_W'(1));

  // Counter restarts at 0 on start, at every boundary, and is held at 0 while stopped.
  always_comb begin
    cnt_next = '0;
    if (run && active && !last) begin
      cnt_next = cnt + DIV_W'(1);
    end
  end

  // At a boundary cnt_next is 0 and half >= 1, so the first cycle of any period is high
  // regardless of which ratio the new period uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      active  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      active  <= run;
      clk_out <= run && (cnt_next < half);
      tick    <= run && (cnt_next == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/stop FSM, ratio handshake and pending-ratio commit at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  clk_div_cfg_if.slave     cfg,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  clk_div_state_t   state;
  clk_div_state_t   next_state;
  logic [DIV_W-1:0] pend_div;
  logic             cfg_err_q;
  logic             ready;
  logic             handshake;
  logic             legal;
  logic             accept;
  logic             last;
  logic             stopping;

  assign handshake = cfg.cfg_valid && ready;
  assign legal     = cfg.cfg_div >= DIV_W'(MIN_DIV);
  assign accept    = handshake && legal;
  assign stopping  = last && !en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // en is level-sensitive: only its value in the boundary cycle decides whether to stop,
  // so a dip that recovers before the boundary has no effect.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (en) next_state = RUN;
      RUN: begin
        if (stopping) begin
          next_state = IDLE;
        end else if (accept) begin
          next_state = PEND;
        end
      end
      PEND: if (last) next_state = en ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state != PEND);
    cfg.cfg_ready = ready;
    cfg.cfg_err   = cfg_err_q;
  end

  // A ratio accepted in the boundary cycle waits for the next boundary, unless that
  // boundary also stops the divider, in which case it is committed straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_div   <= DIV_W'(DEF_DIV);
      pend_div  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= handshake && !legal;
      unique case (state)
        IDLE: if (accept) cur_div <= cfg.cfg_div;
        RUN: begin
          if (accept) begin
            if (stopping) begin
              cur_div <= cfg.cfg_div;
            end else begin
              pend_div <= cfg.cfg_div;
            end
          end
        end
        PEND: if (last) cur_div <= pend_div;
        default: ;
      endcase
    end
  end

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (next_state != IDLE),
    .div     (cur_div),
    .clk_out (clk_out),
    .tick    (tick),
    .last    (last)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: ratio table plus hand-written stop/pending/reset sequences.
module tb_clk_div_ctrl;

  localparam int DIV_W = 16;

  typedef struct {
    int div;
    int exp_high;
    int exp_period;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] cur_div;
  logic             clk_out;
  logic             tick;
  int               checks = 0;
  int               errors = 0;

  clk_div_cfg_if #(.DIV_W(DIV_W)) cfg_bus ();

  clk_div_ctrl #(.DIV_W(DIV_W), .DEF_DIV(500)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg_bus),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic valid_v, input int div_v);
    en                = en_v;
    cfg_bus.cfg_valid = valid_v;
    cfg_bus.cfg_div   = DIV_W'(div_v);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    stepCycle();
    rst = 1'b0;
  endtask

  // One cycle handshake; returns with cfg_valid dropped.
  task automatic offerRatio(input logic en_v, input int div_v);
    applyStimulus(en_v, 1'b1, div_v);
    stepCycle();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Called on a tick cycle; counts cycles and high cycles up to the next tick.
  task automatic measurePeriod(output int period, output int high, output int ready_low);
    period    = 0;
    high      = 0;
    ready_low = 0;
    do begin
      high      += int'(clk_out);
      ready_low += int'(!cfg_bus.cfg_ready);
      period++;
      stepCycle();
    end while (!tick && period < 5000);
  endtask

  task automatic waitTick(input int budget);
    int n = 0;
    while (!tick && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("wait_tick", int'(tick), 1);
  endtask

  initial begin
    vec_t vecs[6];
    int   period;
    int   high;
    int   ready_low;
    int   n;

    vecs[0] = '{div: 5,  exp_high: 2, exp_period: 5};
    vecs[1] = '{div: 2,  exp_high: 1, exp_period: 2};
    vecs[2] = '{div: 3,  exp_high: 1, exp_period: 3};
    vecs[3] = '{div: 8,  exp_high: 4, exp_period: 8};
    vecs[4] = '{div: 9,  exp_high: 4, exp_period: 9};
    vecs[5] = '{div: 16, exp_high: 8, exp_period: 16};

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    stepCycle();

    $display("[TB] reset and default ratio");
    doReset();
    checkOutput("rst_clk_out", int'(clk_out), 0);
    checkOutput("rst_tick", int'(tick), 0);
    checkOutput("rst_cur_div", int'(cur_div), 500);
    checkOutput("rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);
    checkOutput("rst_cfg_err", int'(cfg_bus.cfg_err), 0);
    applyStimulus(1'b1, 1'b0, 0);
    stepCycle();
    checkOutput("start_tick", int'(tick), 1);
    checkOutput("start_clk_out", int'(clk_out), 1);
    for (int p = 0; p < 2; p++) begin
      measurePeriod(period, high, ready_low);
      checkOutput("def_period", period, 500);
      checkOutput("def_high", high, 250);
      checkOutput("def_ready_low", ready_low, 0);
      checkOutput("def_cur_div", int'(cur_div), 500);
    end

    $display("[TB] ratio table programmed in IDLE");
    foreach (vecs[i]) begin
      doReset();
      offerRatio(1'b0, vecs[i].div);
      checkOutput("tbl_cur_div", int'(cur_div), vecs[i].div);
      checkOutput("tbl_idle_tick", int'(tick), 0);
      applyStimulus(1'b1, 1'b0, 0);
      stepCycle();
      checkOutput("tbl_start_tick", int'(tick), 1);
      checkOutput("tbl_start_clk_out", int'(clk_out), 1);
      for (int p = 0; p < 2; p++) begin
        measurePeriod(period, high, ready_low);
        checkOutput("tbl_period", period, vecs[i].exp_period);
        checkOutput("tbl_high", high, vecs[i].exp_high);
      end
    end

    $display("[TB] ratio change while running");
    doReset();
    applyStimulus(1'b1, 1'b0, 0);
    stepCycle();
    for (int k = 0; k < 100; k++) stepCycle();
    offerRatio(1'b1, 100);
    checkOutput("pend_ready", int'(cfg_bus.cfg_ready), 0);
    checkOutput("pend_cur_div", int'(cur_div), 500);
    n = 0;
    while (!tick && n < 1000) begin
      n += int'(!cfg_bus.cfg_ready);
      stepCycle();
    end
    checkOutput("pend_ready_low_cycles", n, 399);
    checkOutput("commit_tick", int'(tick), 1);
    checkOutput("commit_ready", int'(cfg_bus.cfg_ready), 1);
    checkOutput("commit_cur_div", int'(cur_div), 100);
    measurePeriod(period, high, ready_low);
    checkOutput("new_period", period, 100);
    checkOutput("new_high", high, 50);

    $display("[TB] ratio offered in the boundary cycle");
    for (int k = 0; k < 99; k++) stepCycle();
    offerRatio(1'b1, 6);
    checkOutput("bnd_tick", int'(tick), 1);
    checkOutput("bnd_cur_div", int'(cur_div), 100);
    checkOutput("bnd_ready", int'(cfg_bus.cfg_ready), 0);
    measurePeriod(period, high, ready_low);
    checkOutput("bnd_old_period", period, 100);
    checkOutput("bnd_old_high", high, 50);
    checkOutput("bnd_next_cur_div", int'(cur_div), 6);
    measurePeriod(period, high, ready_low);
    checkOutput("bnd_new_period", period, 6);
    checkOutput("bnd_new_high", high, 3);

    $display("[TB] illegal ratios");
    offerRatio(1'b1, 0);
    checkOutput("err0_pulse", int'(cfg_bus.cfg_err), 1);
    checkOutput("err0_ready", int'(cfg_bus.cfg_ready), 1);
    offerRatio(1'b1, 1);
    checkOutput("err1_pulse", int'(cfg_bus.cfg_err), 1);
    checkOutput("err1_ready", int'(cfg_bus.cfg_ready), 1);
    stepCycle();
    checkOutput("err_clear", int'(cfg_bus.cfg_err), 0);
    checkOutput("err_cur_div", int'(cur_div), 6);
    waitTick(20);
    measurePeriod(period, high, ready_low);
    checkOutput("err_period", period, 6);
    checkOutput("err_high", high, 3);

    $display("[TB] stop, restart and cancelled stop");
    doReset();
    offerRatio(1'b0, 8);
    applyStimulus(1'b1, 1'b0, 0);
    stepCycle();
    stepCycle();
    stepCycle();
    en = 1'b0;
    stepCycle();
    for (int k = 3; k < 8; k++) begin
      checkOutput("stop_tail_clk_out", int'(clk_out), (k < 4) ? 1 : 0);
      checkOutput("stop_tail_tick", int'(tick), 0);
      stepCycle();
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("stopped_clk_out", int'(clk_out), 0);
      checkOutput("stopped_tick", int'(tick), 0);
      stepCycle();
    end
    en = 1'b1;
    stepCycle();
    checkOutput("restart_tick", int'(tick), 1);
    checkOutput("restart_clk_out", int'(clk_out), 1);
    stepCycle();
    stepCycle();
    en = 1'b0;
    stepCycle();
    en = 1'b1;
    for (int k = 0; k < 5; k++) stepCycle();
    checkOutput("cancel_tick", int'(tick), 1);
    checkOutput("cancel_clk_out", int'(clk_out), 1);

    $display("[TB] reset while a ratio is pending");
    doReset();
    applyStimulus(1'b1, 1'b0, 0);
    stepCycle();
    for (int k = 0; k < 10; k++) stepCycle();
    offerRatio(1'b1, 100);
    checkOutput("rstp_pend_ready", int'(cfg_bus.cfg_ready), 0);
    doReset();
    checkOutput("rstp_clk_out", int'(clk_out), 0);
    checkOutput("rstp_tick", int'(tick), 0);
    checkOutput("rstp_cur_div", int'(cur_div), 500);
    checkOutput("rstp_ready", int'(cfg_bus.cfg_ready), 1);
    stepCycle();
    checkOutput("rstp_idle_tick", int'(tick), 0);
    en = 1'b1;
    stepCycle();
    checkOutput("rstp_start_tick", int'(tick), 1);
    measurePeriod(period, high, ready_low);
    checkOutput("rstp_period", period, 500);
    measurePeriod(period, high, ready_low);
    checkOutput("rstp_period2", period, 500);
    checkOutput("rstp_cur_div_after", int'(cur_div), 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
